rot_square_gen: RTL and testbench

//  Animation source for the 4-digit seven-segment display: a small square circles the

---
 rtl/rot_square_gen.sv | 105 ++++++++++
 tb/tb_rot_square_gen.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rot_square_gen.sv
// Rotating-square animation source for a 4-digit seven-segment display.
// A prescaler paces a 3-bit position FSM; digit patterns are registered from next-pos.
module rot_square_gen #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       cw,
  output logic [2:0] pos,
  output logic       step,
  output logic [7:0] in3,
  output logic [7:0] in2,
  output logic [7:0] in1,
  output logic [7:0] in0
);

  localparam int              CNT_W   = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  // Active-low patterns, bit order {dp,g,f,e,d,c,b,a}
  localparam logic [7:0] UP    = 8'h9C;
  localparam logic [7:0] LO    = 8'hA3;
  localparam logic [7:0] BLANK = 8'hFF;

  // Position states: upper squares left-to-right, then lower squares right-to-left
  localparam logic [2:0] S_UP3 = 3'd0;
  localparam logic [2:0] S_UP2 = 3'd1;
  localparam logic [2:0] S_UP1 = 3'd2;
  localparam logic [2:0] S_UP0 = 3'd3;
  localparam logic [2:0] S_LO0 = 3'd4;
  localparam logic [2:0] S_LO1 = 3'd5;
  localparam logic [2:0] S_LO2 = 3'd6;
  localparam logic [2:0] S_LO3 = 3'd7;

  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic [2:0]       pos_next;
  logic [7:0]       in3_next;
  logic [7:0]       in2_next;
  logic [7:0]       in1_next;
  logic [7:0]       in0_next;

  // en low in the wrap cycle suppresses the tick
  assign tick = en && (cnt == CNT_MAX);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    pos_next = pos;
    if (tick) begin
      pos_next = cw ? pos + 3'd1 : pos - 3'd1;
    end
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    in3_next = BLANK;
    in2_next = BLANK;
    in1_next = BLANK;
    in0_next = BLANK;
    case (pos_next)
      S_UP3:   in3_next = UP;
      S_UP2:   in2_next = UP;
      S_UP1:   in1_next = UP;
      S_UP0:   in0_next = UP;
      S_LO0:   in0_next = LO;
      S_LO1:   in1_next = LO;
      S_LO2:   in2_next = LO;
      S_LO3:   in3_next = LO;
      default: in3_next = UP;
    endcase
  end

  // Patterns decode from pos_next so they flip on the same edge as pos
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos  <= S_UP3;
      step <= 1'b0;
      in3  <= UP;
      in2  <= BLANK;
      in1  <= BLANK;
      in0  <= BLANK;
    end else begin
      pos  <= pos_next;
      step <= tick;
      in3  <= in3_next;
      in2  <= in2_next;
      in1  <= in1_next;
      in0  <= in0_next;
    end
  end

endmodule

// File: tb/tb_rot_square_gen.sv
// Self-checking bench for rot_square_gen with TICK_DIV=4, using a behavioural
// model that tracks enabled-cycle count and square position as plain integers.
module tb_rot_square_gen;

  localparam int TICK = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       cw;
  logic [2:0] pos;
  logic       step;
  logic [7:0] in3, in2, in1, in0;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int m_cnt  = 0;
  int m_pos  = 0;
  bit m_step = 1'b0;

  rot_square_gen #(.TICK_DIV(TICK)) dut (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .cw   (cw),
    .pos  (pos),
    .step (step),
    .in3  (in3),
    .in2  (in2),
    .in1  (in1),
    .in0  (in0)
  );

  always #5 clk = ~clk;

  // Expected {in3,in2,in1,in0}: top row sweeps left->right for pos 0..3,
  // bottom row right->left for pos 4..7.
  function automatic logic [31:0] pat_for(input int p);
    logic [31:0] r;
    int d;
    r = '1;
    if (p < 4) begin
      d = 3 - p;
      r[8*d +: 8] = 8'h9C;
    end else begin
      d = p - 4;
      r[8*d +: 8] = 8'hA3;
    end
    return r;
  endfunction

  function automatic logic [35:0] expected_vec();
    return {3'(m_pos), m_step, pat_for(m_pos)};
  endfunction

  function automatic logic [35:0] actual_vec();
    return {pos, step, in3, in2, in1, in0};
  endfunction

  task automatic model_reset();
    m_cnt  = 0;
    m_pos  = 0;
    m_step = 1'b0;
  endtask

  // Drive inputs away from the edge, clock once, advance the model, settle.
  task automatic cycle(input logic en_v, input logic cw_v);
    en = en_v;
    cw = cw_v;
    @(posedge clk);
    m_step = 1'b0;
    if (en_v) begin
      m_cnt++;
      if (m_cnt == TICK) begin
        m_cnt  = 0;
        m_step = 1'b1;
        m_pos  = cw_v ? (m_pos + 1) % 8 : (m_pos + 7) % 8;
      end
    end else begin
      m_cnt = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    model_reset();
    #1;
    n_cmp++;
    if (actual_vec() !== expected_vec()) begin
      n_err++;
      $display("FAIL reset_async: got %h want %h", actual_vec(), expected_vec());
    end
    #3 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    en = 1'b0;
    cw = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    n_cmp++;
    if (actual_vec() !== expected_vec()) begin
      n_err++;
      $display("FAIL reset_state: got %h want %h", actual_vec(), expected_vec());
    end
    // Run past one tick, then reset mid-count between edges
    repeat (6) cycle(1'b1, 1'b1);
    n_cmp++;
    if (pos !== 3'd1) begin
      n_err++;
      $display("FAIL pre_reset_pos: got %0d want 1", pos);
    end
    do_reset();
  endtask

  task automatic test_cw_sweep();
    int steps_seen = 0;
    for (int i = 0; i < 8 * TICK; i++) begin
      cycle(1'b1, 1'b1);
      if (step === 1'b1) steps_seen++;
      n_cmp++;
      if (actual_vec() !== expected_vec()) begin
        n_err++;
        $display("FAIL cw_sweep cyc %0d: got %h want %h", i, actual_vec(), expected_vec());
      end
      if (i == 4 * TICK - 1) begin
        n_cmp++;
        if (pos !== 3'd4 || {in3, in2, in1, in0} !== 32'hFFFF_FFA3) begin
          n_err++;
          $display("FAIL cw_pos4: got pos %0d pat %h want pos 4 pat ffffffa3",
                   pos, {in3, in2, in1, in0});
        end
      end
    end
    n_cmp++;
    if (steps_seen != 8 || pos !== 3'd0 || in3 !== 8'h9C) begin
      n_err++;
      $display("FAIL cw_wrap: got steps %0d pos %0d in3 %h want 8 0 9c", steps_seen, pos, in3);
    end
  endtask

  task automatic test_ccw_wrap();
    for (int i = 0; i < 2 * TICK; i++) begin
      cycle(1'b1, 1'b0);
      n_cmp++;
      if (actual_vec() !== expected_vec()) begin
        n_err++;
        $display("FAIL ccw cyc %0d: got %h want %h", i, actual_vec(), expected_vec());
      end
      if (i == TICK - 1) begin
        n_cmp++;
        if (pos !== 3'd7 || in3 !== 8'hA3) begin
          n_err++;
          $display("FAIL ccw_wrap: got pos %0d in3 %h want 7 a3", pos, in3);
        end
      end
    end
    n_cmp++;
    if (pos !== 3'd6 || in2 !== 8'hA3) begin
      n_err++;
      $display("FAIL ccw_second: got pos %0d in2 %h want 6 a3", pos, in2);
    end
  endtask

  task automatic test_freeze();
    logic [2:0] held_pos;
    logic [31:0] held_pat;
    repeat (2) cycle(1'b1, 1'b1);
    held_pos = pos;
    held_pat = {in3, in2, in1, in0};
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b1);
      n_cmp++;
      if (pos !== held_pos || {in3, in2, in1, in0} !== held_pat || step !== 1'b0 ||
          actual_vec() !== expected_vec()) begin
        n_err++;
        $display("FAIL freeze cyc %0d: got %h want %h", i, actual_vec(), expected_vec());
      end
    end
    for (int i = 1; i <= TICK; i++) begin
      cycle(1'b1, 1'b1);
      n_cmp++;
      if (step !== (i == TICK) || actual_vec() !== expected_vec()) begin
        n_err++;
        $display("FAIL resume cyc %0d: got step %b vec %h want step %b vec %h",
                 i, step, actual_vec(), (i == TICK), expected_vec());
      end
    end
  endtask

  task automatic test_dir_flip();
    do_reset();
    repeat (3 * TICK) cycle(1'b1, 1'b1);
    n_cmp++;
    if (pos !== 3'd3 || in0 !== 8'h9C) begin
      n_err++;
      $display("FAIL flip_setup: got pos %0d in0 %h want 3 9c", pos, in0);
    end
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    n_cmp++;
    if (pos !== 3'd3 || step !== 1'b0) begin
      n_err++;
      $display("FAIL flip_between: got pos %0d step %b want 3 0", pos, step);
    end
    cycle(1'b1, 1'b0);
    n_cmp++;
    if (pos !== 3'd2 || in1 !== 8'h9C || step !== 1'b1 || actual_vec() !== expected_vec()) begin
      n_err++;
      $display("FAIL flip_tick: got %h want %h", actual_vec(), expected_vec());
    end
  endtask

  task automatic test_random();
    int lit;
    logic [31:0] pats;
    for (int i = 0; i < 1000; i++) begin
      cycle(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
      pats = {in3, in2, in1, in0};
      lit = 0;
      for (int d = 0; d < 4; d++) begin
        if (pats[8*d +: 8] !== 8'hFF) lit++;
      end
      n_cmp++;
      if (actual_vec() !== expected_vec()) begin
        n_err++;
        $display("FAIL random cyc %0d: got %h want %h", i, actual_vec(), expected_vec());
      end
      n_cmp++;
      if (lit != 1 || {pats[31], pats[23], pats[15], pats[7]} !== 4'b1111) begin
        n_err++;
        $display("FAIL invariant cyc %0d: got lit %0d pats %h want one lit digit, dp off",
                 i, lit, pats);
      end
    end
  endtask

  initial begin
    test_reset();
    test_cw_sweep();
    test_ccw_wrap();
    test_freeze();
    test_dir_flip();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
